// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and helpers for the ID/EX operand stage and its bypass mux.
package id_ex_operand_stage_pkg;

  localparam int REG_W          = 5;
  localparam int XLEN           = 32;
  localparam int CTRL_W_DEFAULT = 16;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // A producer matches a source index only when it actually writes a register.
  function automatic logic reg_match(input logic en, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] idx);
    return en && (rd == idx);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand bypass select: x0, then youngest writer (EX, MEM, WB), then RF data.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [REG_W-1:0] idx,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             ex_en,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             mem_en,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  operand
);

  always_comb begin
    operand = rf_data;
    if (idx == ZERO_REG)
      operand = '0;
    else if (reg_match(ex_en, ex_rd, idx))
      operand = ex_data;
    else if (reg_match(mem_en, mem_rd, idx))
      operand = mem_data;
    // RF write lands on the same edge as this read, so WB must bypass.
    else if (reg_match(wb_en, wb_rd, idx))
      operand = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: RF read, operand bypass, load-use stall and EX slot register.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [REG_W-1:0]  rf_rR1,
  output logic [REG_W-1:0]  rf_rR2,
  input  logic [XLEN-1:0]   rf_rD1,
  input  logic [XLEN-1:0]   rf_rD2,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              mem_rf_we,
  input  logic [XLEN-1:0]   mem_wD,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_wD,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_rf_we,
  output logic              ex_is_load,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              vld_p1, we_p1, load_p1;
  logic [XLEN-1:0]   pc_p1, imm_p1, rs1_val_p1, rs2_val_p1;
  logic [REG_W-1:0]  rd_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CNT_W-1:0]  lu_cnt, fl_cnt;

  logic              ex_fwd_en, hz;
  logic [XLEN-1:0]   op1_p0, op2_p0;

  assign rf_rR1 = id_rs1;
  assign rf_rR2 = id_rs2;

  // A load in EX has no result yet; only ALU results may bypass from EX.
  assign ex_fwd_en = vld_p1 && we_p1 && !load_p1;

  id_ex_operand_stage_fwd_mux u_fwd_rs1 (
    .idx(id_rs1), .rf_data(rf_rD1),
    .ex_en(ex_fwd_en), .ex_rd(rd_p1), .ex_data(ex_alu_result),
    .mem_en(mem_rf_we), .mem_rd(mem_rd), .mem_data(mem_wD),
    .wb_en(wb_we), .wb_rd(wb_rd), .wb_data(wb_wD),
    .operand(op1_p0)
  );

  id_ex_operand_stage_fwd_mux u_fwd_rs2 (
    .idx(id_rs2), .rf_data(rf_rD2),
    .ex_en(ex_fwd_en), .ex_rd(rd_p1), .ex_data(ex_alu_result),
    .mem_en(mem_rf_we), .mem_rd(mem_rd), .mem_data(mem_wD),
    .wb_en(wb_we), .wb_rd(wb_rd), .wb_data(wb_wD),
    .operand(op2_p0)
  );

  assign hz = id_valid && vld_p1 && load_p1 && (rd_p1 != ZERO_REG) &&
              (reg_match(id_rs1_used, rd_p1, id_rs1) ||
               reg_match(id_rs2_used, rd_p1, id_rs2));

  assign id_stall = !flush && (hz || !ex_ready);

  // ID -> EX slot (p0 -> p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      we_p1      <= 1'b0;
      load_p1    <= 1'b0;
      pc_p1      <= '0;
      imm_p1     <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      rd_p1      <= '0;
      ctrl_p1    <= '0;
      lu_cnt     <= '0;
      fl_cnt     <= '0;
    end else if (flush) begin
      // Killed slot also drops its write/load flags so no bubble carries rf_we.
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      load_p1 <= 1'b0;
      fl_cnt  <= sat_inc(fl_cnt);
    end else if (!ex_ready) begin
      vld_p1 <= vld_p1;
    end else if (hz) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      load_p1 <= 1'b0;
      lu_cnt  <= sat_inc(lu_cnt);
    end else begin
      vld_p1     <= id_valid;
      we_p1      <= id_valid && id_rf_we;
      load_p1    <= id_valid && id_is_load;
      pc_p1      <= id_pc;
      imm_p1     <= id_imm;
      rs1_val_p1 <= op1_p0;
      rs2_val_p1 <= op2_p0;
      rd_p1      <= id_rd;
      ctrl_p1    <= id_ctrl;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_rf_we     = we_p1;
  assign ex_is_load   = load_p1;
  assign ex_pc        = pc_p1;
  assign ex_imm       = imm_p1;
  assign ex_rs1_val   = rs1_val_p1;
  assign ex_rs2_val   = rs2_val_p1;
  assign ex_rd        = rd_p1;
  assign ex_ctrl      = ctrl_p1;
  assign load_use_cnt = lu_cnt;
  assign flush_cnt    = fl_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scenarios plus randomized traffic checked against a behavioural EX-slot model.
module tb_id_ex_operand_stage;

  localparam int CW   = 16;
  localparam int NW   = 4;
  localparam int MAXC = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs1_used, id_rs2_used, id_rf_we, id_is_load;
  logic [31:0]   id_pc, id_imm, rf_rD1, rf_rD2, ex_alu_result, mem_wD, wb_wD;
  logic [4:0]    id_rs1, id_rs2, id_rd, mem_rd, wb_rd, rf_rR1, rf_rR2, ex_rd;
  logic [CW-1:0] id_ctrl, ex_ctrl;
  logic          mem_rf_we, wb_we, ex_ready, flush;
  logic          id_stall, ex_valid, ex_rf_we, ex_is_load;
  logic [31:0]   ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [NW-1:0] load_use_cnt, flush_cnt;

  id_ex_operand_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rf_we(id_rf_we), .id_is_load(id_is_load), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_rR1(rf_rR1), .rf_rR2(rf_rR2), .rf_rD1(rf_rD1), .rf_rD2(rf_rD2),
    .ex_alu_result(ex_alu_result), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_wD(mem_wD),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wD(wb_wD), .ex_ready(ex_ready), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model of the EX slot and the two event counters.
  logic          m_valid, m_we, m_load;
  logic [31:0]   m_pc, m_imm, m_v1, m_v2;
  logic [4:0]    m_rd;
  logic [CW-1:0] m_ctrl;
  int            m_luc, m_fc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Youngest in-flight producer of s wins; x0 is always zero.
  function automatic logic [31:0] m_operand(input logic [4:0] s, input logic [31:0] rf);
    logic        en  [3];
    logic [4:0]  rd  [3];
    logic [31:0] val [3];
    if (s == 5'd0) return 32'd0;
    en  = '{m_valid && m_we && !m_load, mem_rf_we, wb_we};
    rd  = '{m_rd, mem_rd, wb_rd};
    val = '{ex_alu_result, mem_wD, wb_wD};
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] == s) return val[i];
    return rf;
  endfunction

  function automatic logic m_hazard();
    if (!(id_valid && m_valid && m_load && m_rd != 5'd0)) return 1'b0;
    return (id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd);
  endfunction

  task automatic m_reset();
    {m_valid, m_we, m_load} = 3'b000;
    m_pc = 0; m_imm = 0; m_v1 = 0; m_v2 = 0; m_rd = 0; m_ctrl = 0;
    m_luc = 0; m_fc = 0;
  endtask

  // Called at negedge with inputs applied; returns at the following negedge.
  task automatic step();
    logic        hz;
    logic [31:0] o1, o2;
    #1;
    hz = m_hazard();
    chk("id_stall", id_stall, (!flush) && (hz || !ex_ready));
    chk("rf_rR1", rf_rR1, id_rs1);
    chk("rf_rR2", rf_rR2, id_rs2);
    o1 = m_operand(id_rs1, rf_rD1);
    o2 = m_operand(id_rs2, rf_rD2);
    @(posedge clk);
    if (rst) m_reset();
    else if (flush) begin
      {m_valid, m_we, m_load} = 3'b000;
      if (m_fc < MAXC) m_fc++;
    end else if (!ex_ready) begin
    end else if (hz) begin
      {m_valid, m_we, m_load} = 3'b000;
      if (m_luc < MAXC) m_luc++;
    end else begin
      m_valid = id_valid; m_we = id_valid && id_rf_we; m_load = id_valid && id_is_load;
      m_pc = id_pc; m_imm = id_imm; m_v1 = o1; m_v2 = o2; m_rd = id_rd; m_ctrl = id_ctrl;
    end
    @(negedge clk);
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_rf_we", ex_rf_we, m_we);
    chk("ex_is_load", ex_is_load, m_load);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rs1_val", ex_rs1_val, m_v1);
    chk("ex_rs2_val", ex_rs2_val, m_v2);
    chk("ex_rd", ex_rd, m_rd);
    chk("ex_ctrl", ex_ctrl, m_ctrl);
    chk("load_use_cnt", load_use_cnt, m_luc);
    chk("flush_cnt", flush_cnt, m_fc);
    chk("bubble_no_we", ex_rf_we && !ex_valid, 1'b0);
  endtask

  task automatic idle();
    rst = 0; flush = 0; ex_ready = 1;
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rf_we = 0; id_is_load = 0;
    id_imm = 0; id_ctrl = 0; rf_rD1 = 0; rf_rD2 = 0; ex_alu_result = 0;
    mem_rd = 0; mem_rf_we = 0; mem_wD = 0; wb_rd = 0; wb_we = 0; wb_wD = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic ld, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_pc = pc; id_rd = rd; id_rf_we = we; id_is_load = ld;
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = 1; id_rs2_used = 1;
    id_imm = pc ^ 32'h5A5A; id_ctrl = pc[15:0];
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    m_reset();
    @(negedge clk);

    // Reset state
    rst = 1;
    step();
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_cnt", {load_use_cnt, flush_cnt}, '0);
    rst = 0;

    // add x3 = x1 + x2 from the register file
    instr(32'h0, 5'd3, 1, 0, 5'd1, 5'd2);
    rf_rD1 = 5; rf_rD2 = 7;
    step();
    chk("add_valid", ex_valid, 1'b1);
    chk("add_rs1", ex_rs1_val, 32'd5);
    chk("add_rs2", ex_rs2_val, 32'd7);

    // Bypass priority EX > MEM > WB on x5
    instr(32'h4, 5'd5, 1, 0, 5'd0, 5'd0);
    step();
    instr(32'h8, 5'd7, 0, 0, 5'd5, 5'd0);
    rf_rD1 = 32'h99;
    ex_alu_result = 32'h10;
    mem_rd = 5; mem_rf_we = 1; mem_wD = 32'h20;
    wb_rd = 5; wb_we = 1; wb_wD = 32'h30;
    step();
    chk("fwd_ex", ex_rs1_val, 32'h10);
    step();
    chk("fwd_mem", ex_rs1_val, 32'h20);
    mem_rf_we = 0;
    step();
    chk("fwd_wb", ex_rs1_val, 32'h30);
    wb_we = 0;

    // Load-use: lw x6 then a consumer of x6 on rs2
    instr(32'h10, 5'd6, 1, 1, 5'd0, 5'd0);
    step();
    instr(32'h14, 5'd8, 1, 0, 5'd0, 5'd6);
    #1;
    chk("lu_stall", id_stall, 1'b1);
    step();
    chk("lu_bubble", {ex_valid, ex_rf_we}, 2'b00);
    chk("lu_cnt", load_use_cnt, 1);
    mem_rd = 6; mem_rf_we = 1; mem_wD = 32'hDEAD;
    #1;
    chk("lu_nostall", id_stall, 1'b0);
    step();
    chk("lu_mem_fwd", ex_rs2_val, 32'hDEAD);
    chk("lu_valid", ex_valid, 1'b1);

    // x0 reads zero even while MEM claims to write it
    instr(32'h18, 5'd9, 1, 0, 5'd0, 5'd0);
    rf_rD1 = 32'h1234; mem_rd = 0; mem_rf_we = 1; mem_wD = 32'hFFFF_FFFF;
    step();
    chk("x0_zero", ex_rs1_val, 32'd0);
    mem_rf_we = 0;

    // EX back-pressure with a flush in the middle
    instr(32'h100, 5'd9, 1, 0, 5'd1, 5'd2);
    step();
    ex_ready = 0; id_pc = 32'h200;
    #1;
    chk("bp_stall", id_stall, 1'b1);
    step();
    chk("bp_hold_pc", ex_pc, 32'h100);
    chk("bp_hold_valid", ex_valid, 1'b1);
    flush = 1;
    #1;
    chk("bp_flush_nostall", id_stall, 1'b0);
    step();
    chk("bp_flush_valid", ex_valid, 1'b0);
    chk("bp_flush_cnt", flush_cnt, 1);
    flush = 0;
    step();
    chk("bp_after_pc", ex_pc, 32'h100);
    ex_ready = 1;

    // Drive the load-use counter into saturation
    for (int i = 0; i < MAXC + 4; i++) begin
      instr(32'h300 + 8 * i, 5'd4, 1, 1, 5'd0, 5'd0);
      step();
      instr(32'h304 + 8 * i, 5'd2, 1, 0, 5'd4, 5'd0);
      step();
    end
    chk("lu_sat", load_use_cnt, MAXC);

    // Reset lands in the middle of a stall
    instr(32'h400, 5'd4, 1, 1, 5'd0, 5'd0);
    step();
    instr(32'h404, 5'd2, 1, 0, 5'd4, 5'd0);
    ex_ready = 0; rst = 1;
    step();
    chk("rst_mid_valid", ex_valid, 1'b0);
    chk("rst_mid_data", {ex_pc, ex_rs1_val}, 64'd0);
    chk("rst_mid_cnt", {load_use_cnt, flush_cnt}, '0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(99) == 0);
      flush       = ($urandom_range(9) == 0);
      ex_ready    = ($urandom_range(4) != 0);
      id_valid    = ($urandom_range(3) != 0);
      id_pc       = $urandom;
      id_imm      = $urandom;
      id_ctrl     = CW'($urandom);
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      id_rd       = 5'($urandom_range(3));
      id_rs1_used = $urandom_range(1);
      id_rs2_used = $urandom_range(1);
      id_rf_we    = $urandom_range(1);
      id_is_load  = ($urandom_range(2) == 0);
      rf_rD1      = $urandom;
      rf_rD2      = $urandom;
      ex_alu_result = $urandom;
      mem_rd      = 5'($urandom_range(3));
      mem_rf_we   = $urandom_range(1);
      mem_wD      = $urandom;
      wb_rd       = 5'($urandom_range(3));
      wb_we       = $urandom_range(1);
      wb_wD       = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX boundary stage directly downstream of the register file: drives RF read addresses, takes RF read data, applies EX/MEM/WB bypassing, detects load-use hazards and registers the decoded instruction into the EX pipeline slot.
- Produces the stall request back to IF/ID and accepts a flush from branch resolution in EX.

Parameters:
- CTRL_W, 16, width of opaque decoded control bundle passed to EX
- CNT_W, 32, width of saturating performance counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds an instruction
- id_pc  in  32  instruction PC
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_rs1_used, id_rs2_used  in  1  operand actually read by instruction
- id_rf_we, id_is_load  in  1  writes rd / is a load
- id_imm  in  32  decoded immediate
- id_ctrl  in  CTRL_W  control bundle
- rf_rR1, rf_rR2  out  5  RF read addresses (combinational = id_rs1/id_rs2)
- rf_rD1, rf_rD2  in  32  RF async read data
- ex_alu_result  in  32  result of instruction currently in EX
- mem_rd  in  5; mem_rf_we  in  1; mem_wD  in  32  MEM-stage writer
- wb_rd  in  5; wb_we  in  1; wb_wD  in  32  WB-stage writer (same as RF write port)
- ex_ready  in  1  EX can accept a new instruction this cycle
- flush  in  1  kill EX slot (branch/jump redirect)
- id_stall  out  1  hold IF/ID this cycle (combinational)
- ex_valid, ex_rf_we, ex_is_load  out  1  registered EX slot
- ex_pc, ex_imm, ex_rs1_val, ex_rs2_val  out  32  registered
- ex_rd  out  5; ex_ctrl  out  CTRL_W  registered
- load_use_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: all registered outputs and counters 0 (ex_valid=0 = bubble).
- Operand select per source s (rs1/rs2), priority high→low: s==0 → 0; EX match (ex_valid & ex_rf_we & !ex_is_load & ex_rd==s) → ex_alu_result; MEM match (mem_rf_we & mem_rd==s) → mem_wD; WB match (wb_we & wb_rd==s) → wb_wD (RF write lands at edge, so WB bypass is mandatory); else rf_rDx.
- Load-use hazard: hz = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)).
- id_stall = hz | !ex_ready, forced 0 when flush=1.
- Update at edge, priority: rst > flush > !ex_ready > hz > normal.
  - flush: ex_valid<=0, other fields don't-care (hold); flush_cnt+=1 saturating. Flush wins over hz and !ex_ready.
  - !ex_ready: hold every EX field unchanged, no counter update.
  - hz: insert bubble (ex_valid<=0, ex_rf_we<=0, ex_is_load<=0); load_use_cnt+=1 saturating. Next cycle the load is in MEM and resolves via MEM bypass.
  - normal: latch id_* fields and selected operands; ex_valid<=id_valid; ex_rf_we/ex_is_load gated by id_valid.
- Latency: 1 cycle ID→EX; load-use costs exactly 1 bubble.
- Counters saturate at all-ones, never wrap.
- Bubble must never carry rf_we=1.

Decomposition:
- Shared package/defines: REG_W=5, XLEN=32, CTRL_W, ZERO_REG constant.
- One sub-module natural: fwd_mux (index, RF data, EX/MEM/WB candidates → operand), instantiated twice.

Test Plan:
- Reset then add x3=x1+x2 with RF x1=5, x2=7, no writers → next cycle ex_valid=1, ex_rs1_val=5, ex_rs2_val=7.
- Back-to-back: EX holds addi x5 result 0x10, MEM writes x5=0x20, WB writes x5=0x30; ID reads x5 → ex_rs1_val=0x10; drop EX → 0x20; drop MEM → 0x30.
- lw x6 in EX, ID uses x6 as rs2 → id_stall=1 one cycle, bubble ex_valid=0, load_use_cnt=1; next cycle MEM bypass supplies mem_wD=0xDEAD.
- Read x0 while MEM writes x0=0xFFFF_FFFF → ex_rs1_val=0.
- ex_ready=0 for 3 cycles → EX fields stable, id_stall=1; flush asserted in cycle 2 → ex_valid=0, flush_cnt=1, id_stall=0 that cycle.
- Force load_use_cnt to all-ones, trigger hazard → counter stays all-ones; assert rst mid-stall → all outputs 0 next edge.
